// File: rtl/fc_layer_sequencer_if.sv
// Buffer, engine and output-buffer signals between the FC layer sequencer and its neighbours.
// The master modport is the sequencer side.
interface fc_layer_sequencer_if #(
    parameter int FA_W = 3,
    parameter int WA_W = 7,
    parameter int OA_W = 4
);
    logic            feat_rd_en;
    logic [FA_W-1:0] feat_addr;
    logic [255:0]    feat_data;
    logic            wgt_rd_en;
    logic [WA_W-1:0] wgt_addr;
    logic [255:0]    wgt_data;
    logic            acc_en;
    logic [255:0]    acc_feature;
    logic [255:0]    acc_weight;
    logic            acc_done;
    logic [19:0]     acc_result;
    logic            out_valid;
    logic [OA_W-1:0] out_addr;
    logic [7:0]      out_data;

    modport master (
        output feat_rd_en, feat_addr, wgt_rd_en, wgt_addr,
        output acc_en, acc_feature, acc_weight,
        output out_valid, out_addr, out_data,
        input  feat_data, wgt_data, acc_done, acc_result
    );

    modport slave (
        input  feat_rd_en, feat_addr, wgt_rd_en, wgt_addr,
        input  acc_en, acc_feature, acc_weight,
        input  out_valid, out_addr, out_data,
        output feat_data, wgt_data, acc_done, acc_result
    );
endinterface

// File: rtl/fc_layer_sequencer.sv
// Runs one fully-connected layer through a single 32-element dot-product engine,
// accumulating per-slice results and writing ReLU/shift/saturated 8-bit outputs.
module fc_layer_sequencer #(
    parameter int IN_CHUNKS   = 8,
    parameter int OUT_NEURONS = 10,
    parameter int ACC_WIDTH   = 24,
    parameter int SHIFT       = 8,
    parameter int FA_W        = 3,
    parameter int WA_W        = 7,
    parameter int OA_W        = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic start,
    output logic busy,
    output logic done,
    fc_layer_sequencer_if.master lyr
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_RUN, S_RELEASE, S_WRITE, S_DONE
    } state_t;

    state_t                 state, next_state;
    logic [FA_W-1:0]        chunk;
    logic [OA_W-1:0]        neuron;
    logic signed [ACC_WIDTH-1:0] psum;
    logic                   en_seen;
    logic                   last_chunk, last_neuron, acc_complete;
    logic [ACC_WIDTH-1:0]   relu, shifted;
    logic [7:0]             quant;

    assign last_chunk   = (chunk == FA_W'(IN_CHUNKS - 1));
    assign last_neuron  = (neuron == OA_W'(OUT_NEURONS - 1));
    // en_seen guarantees acc_en was already high for a cycle, so a stale acc_done is ignored
    assign acc_complete = lyr.acc_done && en_seen;

    assign relu    = psum[ACC_WIDTH-1] ? '0 : psum;
    assign shifted = relu >> SHIFT;
    assign quant   = (shifted >= ACC_WIDTH'(255)) ? 8'hFF : shifted[7:0];

    assign lyr.feat_addr = chunk;
    assign lyr.wgt_addr  = WA_W'(neuron) * WA_W'(IN_CHUNKS) + WA_W'(chunk);
    assign lyr.out_addr  = neuron;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        // NOTE: non-blocking assignments keep every register update order-independent.
        else       state <= next_state;
    end

    always_comb begin
        // NOTE: every signal gets a default first so no branch can infer a latch.
        next_state     = state;
        busy           = 1'b0;
        done           = 1'b0;
        lyr.feat_rd_en = 1'b0;
        lyr.wgt_rd_en  = 1'b0;
        lyr.acc_en     = 1'b0;
        lyr.out_valid  = 1'b0;
        lyr.out_data   = 8'd0;
        unique case (state)
            S_IDLE:  if (start) next_state = S_FETCH;
            S_FETCH: begin
                busy           = 1'b1;
                lyr.feat_rd_en = 1'b1;
                lyr.wgt_rd_en  = 1'b1;
                next_state     = S_LOAD;
            end
            S_LOAD: begin
                busy       = 1'b1;
                next_state = S_RUN;
            end
            S_RUN: begin
                busy       = 1'b1;
                lyr.acc_en = 1'b1;
                if (acc_complete) next_state = S_RELEASE;
            end
            S_RELEASE: begin
                busy = 1'b1;
                if (!lyr.acc_done) next_state = last_chunk ? S_WRITE : S_FETCH;
            end
            S_WRITE: begin
                busy          = 1'b1;
                lyr.out_valid = 1'b1;
                lyr.out_data  = quant;
                next_state    = last_neuron ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chunk           <= '0;
            neuron          <= '0;
            psum            <= '0;
            en_seen         <= 1'b0;
            // NOTE: the slice registers are reset too, so an aborted layer leaves zeros on the engine bus.
            lyr.acc_feature <= '0;
            lyr.acc_weight  <= '0;
        end else begin
            en_seen <= (state == S_RUN);
            unique case (state)
                S_IDLE: if (start) begin
                    psum   <= '0;
                    chunk  <= '0;
                    neuron <= '0;
                end
                S_LOAD: begin
                    lyr.acc_feature <= lyr.feat_data;
                    lyr.acc_weight  <= lyr.wgt_data;
                end
                S_RUN: if (acc_complete)
                    psum <= psum + {{(ACC_WIDTH-20){lyr.acc_result[19]}}, lyr.acc_result};
                S_RELEASE: if (!lyr.acc_done && !last_chunk) chunk <= chunk + FA_W'(1);
                S_WRITE: begin
                    psum  <= '0;
                    chunk <= '0;
                    if (!last_neuron) neuron <= neuron + OA_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Self-checking bench: two sequencer instances (2x2 layer with no shift, 8-chunk layer with
// shift 8) driven by buffer and engine models, with a scoreboard of expected neuron writes.
module tb_fc_layer_sequencer;

    localparam int IC_A = 2, ON_A = 2;
    localparam int IC_B = 8, ON_B = 2;
    localparam int LAT_A = 3, HOLD_A = 2;
    localparam int LAT_B = 2, HOLD_B = 0;
    localparam int BOUND = 3000;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0;
    logic busy_a, done_a, busy_b, done_b;

    fc_layer_sequencer_if #(.FA_W(1), .WA_W(2), .OA_W(1)) ia ();
    fc_layer_sequencer_if #(.FA_W(3), .WA_W(4), .OA_W(1)) ib ();

    fc_layer_sequencer #(.IN_CHUNKS(IC_A), .OUT_NEURONS(ON_A), .ACC_WIDTH(24), .SHIFT(0),
                         .FA_W(1), .WA_W(2), .OA_W(1))
        dut_a (.clk(clk), .rstn(rstn), .start(start_a), .busy(busy_a), .done(done_a), .lyr(ia));

    fc_layer_sequencer #(.IN_CHUNKS(IC_B), .OUT_NEURONS(ON_B), .ACC_WIDTH(24), .SHIFT(8),
                         .FA_W(3), .WA_W(4), .OA_W(1))
        dut_b (.clk(clk), .rstn(rstn), .start(start_b), .busy(busy_b), .done(done_b), .lyr(ib));

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    int done_cnt_a = 0, done_cnt_b = 0;
    exp_t sb_a[$], sb_b[$];
    exp_t ea, eb;
    logic [1:0] waddr_q[$];
    logic       faddr_q[$];
    logic [255:0] feat_a[IC_A], wgt_a[IC_A*ON_A];
    logic [255:0] feat_b[IC_B], wgt_b[IC_B*ON_B];
    int cnt_a = 0, hcnt_a = 0, cnt_b = 0, hcnt_b = 0;
    bit p1_rd = 0, p2_rd = 0, p_en = 0, p_done = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int dot(input logic [255:0] f, input logic [255:0] w);
        int s = 0;
        for (int i = 0; i < 32; i++)
            s += int'($signed(f[8*i +: 8])) * int'($signed(w[8*i +: 8]));
        return s;
    endfunction

    function automatic logic [255:0] fill(input logic [7:0] b);
        return {32{b}};
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Reference for the 2x2 instance: ReLU then clamp to 255 (no shift on this instance)
    function automatic logic [7:0] model_a(input int n);
        longint p = 0;
        for (int c = 0; c < IC_A; c++) p += longint'(dot(feat_a[c], wgt_a[n*IC_A + c]));
        if (p < 0) p = 0;
        if (p > 255) p = 255;
        return p[7:0];
    endfunction

    task automatic push_a(input int a, input int d);
        sb_a.push_back({4'(a), 8'(d)});
    endtask

    // Buffer models: data valid the cycle after the read strobe
    always @(posedge clk) begin
        if (ia.feat_rd_en) ia.feat_data <= feat_a[ia.feat_addr];
        if (ia.wgt_rd_en)  ia.wgt_data  <= wgt_a[ia.wgt_addr];
        if (ib.feat_rd_en) ib.feat_data <= feat_b[ib.feat_addr];
        if (ib.wgt_rd_en)  ib.wgt_data  <= wgt_b[ib.wgt_addr];
    end

    // Engine models: done after LAT enabled cycles, held HOLD cycles after acc_en drops
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ia.acc_done <= 1'b0; ia.acc_result <= '0; cnt_a <= 0; hcnt_a <= 0;
        end else if (ia.acc_done) begin
            if (!ia.acc_en) begin
                if (hcnt_a == 0) ia.acc_done <= 1'b0;
                else hcnt_a <= hcnt_a - 1;
            end
        end else if (ia.acc_en) begin
            if (cnt_a == LAT_A - 1) begin
                ia.acc_done <= 1'b1;
                ia.acc_result <= 20'(dot(ia.acc_feature, ia.acc_weight));
                cnt_a <= 0; hcnt_a <= HOLD_A;
            end else cnt_a <= cnt_a + 1;
        end
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ib.acc_done <= 1'b0; ib.acc_result <= '0; cnt_b <= 0; hcnt_b <= 0;
        end else if (ib.acc_done) begin
            if (!ib.acc_en) begin
                if (hcnt_b == 0) ib.acc_done <= 1'b0;
                else hcnt_b <= hcnt_b - 1;
            end
        end else if (ib.acc_en) begin
            if (cnt_b == LAT_B - 1) begin
                ib.acc_done <= 1'b1;
                ib.acc_result <= 20'(dot(ib.acc_feature, ib.acc_weight));
                cnt_b <= 0; hcnt_b <= HOLD_B;
            end else cnt_b <= cnt_b + 1;
        end
    end

    // Monitor: scoreboard pops and handshake checks, sampled on the falling edge
    always @(negedge clk) begin
        if (!rstn) begin
            p1_rd = 0; p2_rd = 0; p_en = 0; p_done = 0;
        end else begin
            if (ia.out_valid) begin
                if (sb_a.size() == 0) check("unexpected_out_a", 1'b1, 1'b0);
                else begin
                    ea = sb_a.pop_front();
                    check("out_addr_a", ia.out_addr, ea.addr[0]);
                    check("out_data_a", ia.out_data, ea.data);
                end
            end
            if (ib.out_valid) begin
                if (sb_b.size() == 0) check("unexpected_out_b", 1'b1, 1'b0);
                else begin
                    eb = sb_b.pop_front();
                    check("out_addr_b", ib.out_addr, eb.addr[0]);
                    check("out_data_b", ib.out_data, eb.data);
                end
            end
            if (done_a) begin done_cnt_a++; check("busy_in_done_a", busy_a, 1'b0); end
            if (done_b) begin done_cnt_b++; check("busy_in_done_b", busy_b, 1'b0); end
            if (ia.feat_rd_en || ia.wgt_rd_en) begin
                check("rd_en_pair", ia.wgt_rd_en, ia.feat_rd_en);
                check("fetch_with_done_high", ia.acc_done, 1'b0);
                waddr_q.push_back(ia.wgt_addr);
                faddr_q.push_back(ia.feat_addr);
            end
            if (p1_rd) check("acc_en_in_load", ia.acc_en, 1'b0);
            if (p2_rd) check("acc_en_after_load", ia.acc_en, 1'b1);
            if (p_en && p_done) check("acc_en_drop", ia.acc_en, 1'b0);
            p2_rd = p1_rd; p1_rd = ia.feat_rd_en;
            p_en = ia.acc_en; p_done = ia.acc_done;
        end
    end

    task automatic check_zero_a(input string tag);
        check({tag, "_busy"}, busy_a, 1'b0);
        check({tag, "_done"}, done_a, 1'b0);
        check({tag, "_rd_en"}, {ia.feat_rd_en, ia.wgt_rd_en}, 2'b00);
        check({tag, "_acc_en"}, ia.acc_en, 1'b0);
        check({tag, "_out_valid"}, ia.out_valid, 1'b0);
        check({tag, "_out_data"}, ia.out_data, 8'd0);
        check({tag, "_addrs"}, {ia.feat_addr, ia.wgt_addr, ia.out_addr}, 4'd0);
        check({tag, "_acc_bus"}, ia.acc_feature | ia.acc_weight, 256'd0);
    endtask

    task automatic run_layer(input bit use_b, input bit poke_run, input bit poke_done);
        int d0, n;
        bit poked;
        d0 = use_b ? done_cnt_b : done_cnt_a;
        @(negedge clk);
        check("busy_idle", use_b ? busy_b : busy_a, 1'b0);
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        check("busy_after_start", use_b ? busy_b : busy_a, 1'b1);
        n = 0; poked = 0;
        while ((use_b ? done_b : done_a) == 1'b0 && n < BOUND) begin
            if (poke_run && !poked && ia.acc_en) begin start_a = 1'b1; poked = 1; end
            else start_a = 1'b0;
            @(negedge clk);
            n++;
        end
        start_a = 1'b0;
        check("done_within_bound", n < BOUND, 1'b1);
        check("scoreboard_drained", use_b ? sb_b.size() : sb_a.size(), 0);
        if (poke_done) start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("busy_after_done", use_b ? busy_b : busy_a, 1'b0);
        @(negedge clk);
        check("still_idle", use_b ? {busy_b, ib.feat_rd_en} : {busy_a, ia.feat_rd_en}, 2'b00);
        check("one_done_pulse", (use_b ? done_cnt_b : done_cnt_a) - d0, 1);
    endtask

    initial begin
        int n;
        logic [1:0] exp_w[4];
        logic       exp_f[4];
        logic [255:0] s;
        exp_w = '{2'd0, 2'd1, 2'd2, 2'd3};
        exp_f = '{1'b0, 1'b1, 1'b0, 1'b1};

        #3 rstn = 1'b0;
        #1 check_zero_a("reset");
        check("reset_b", {busy_b, done_b, ib.acc_en, ib.out_valid}, 4'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // All-ones 2x2 layer: 64 products of 1 per neuron, addresses 0..3
        foreach (feat_a[i]) feat_a[i] = fill(8'd1);
        foreach (wgt_a[i])  wgt_a[i]  = fill(8'd1);
        waddr_q.delete(); faddr_q.delete();
        push_a(0, 64); push_a(1, 64);
        run_layer(0, 0, 0);
        check("fetch_count", waddr_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("wgt_addr_seq", waddr_q[i], exp_w[i]);
            check("feat_addr_seq", faddr_q[i], exp_f[i]);
        end

        // Negative sum (-160 per slice) clamps to 0
        foreach (feat_a[i]) feat_a[i] = fill(8'd5);
        foreach (wgt_a[i])  wgt_a[i]  = fill(8'hFF);
        push_a(0, 0); push_a(1, 0);
        run_layer(0, 0, 0);

        // Saturation edge: psum 256 -> 255 and 254 -> 254
        foreach (feat_a[i]) feat_a[i] = fill(8'd1);
        s = fill(8'd4); s[7:0] = 8'd2;
        wgt_a[0] = fill(8'd4); wgt_a[1] = fill(8'd4);
        wgt_a[2] = fill(8'd4); wgt_a[3] = s;
        push_a(0, 255); push_a(1, 254);
        run_layer(0, 0, 0);

        // psum exactly 255 -> 255 and exactly 0 -> 0
        s = fill(8'd4); s[7:0] = 8'd3;
        wgt_a[0] = fill(8'd4); wgt_a[1] = s;
        wgt_a[2] = fill(8'd1); wgt_a[3] = fill(8'hFF);
        push_a(0, 255); push_a(1, 0);
        run_layer(0, 0, 0);

        // Random data, start pulsed during RUN and again in the DONE cycle
        for (int r = 0; r < 3; r++) begin
            foreach (feat_a[i]) feat_a[i] = rnd256();
            foreach (wgt_a[i])  wgt_a[i]  = rnd256();
            for (int k = 0; k < ON_A; k++) push_a(k, model_a(k));
            run_layer(0, 1, 1);
        end

        // Reset during RUN of neuron 1 aborts cleanly
        foreach (feat_a[i]) feat_a[i] = fill(8'd1);
        foreach (wgt_a[i])  wgt_a[i]  = fill(8'd1);
        push_a(0, 64); push_a(1, 64);
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        n = 0;
        while (!(ia.out_addr == 1'b1 && ia.acc_en) && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check("reached_run_n1", n < BOUND, 1'b1);
        #2 rstn = 1'b0;
        #1 check_zero_a("abort");
        sb_a.delete();
        repeat (2) @(negedge clk);
        check("no_done_on_abort", done_a, 1'b0);
        rstn = 1'b1;
        push_a(0, 64); push_a(1, 64);
        run_layer(0, 0, 0);

        // 8-chunk instance, shift 8: 16129 saturates, 32512>>8 = 127
        foreach (feat_b[i]) feat_b[i] = fill(8'd127);
        for (int c = 0; c < IC_B; c++) begin
            wgt_b[c]        = fill(8'd127);
            wgt_b[IC_B + c] = fill(8'd1);
        end
        sb_b.push_back({4'd0, 8'd255});
        sb_b.push_back({4'd1, 8'd127});
        run_layer(1, 0, 0);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
